fp32_subtractor_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision subtractor; computes resultSub = A − B.
- It is the subtract-direction counterpart of the existing combinational adder and uses the same 2-bit rounding-mode encoding and the same error/overflow flag convention.
- It sits on the FPU execute path behind a start/done handshake.
- Unlike the adder, it keeps guard/round/sticky bits and handles special operands.

---
 rtl/fp32_subtractor_seq_if.sv | 24 ++
 rtl/fp32_subtractor_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_fp32_subtractor_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fp32_subtractor_seq_if.sv
// Start/done request bundle for the sequential FP32 subtractor.
// Handshake: start is sampled only while the unit is idle; busy is high from the cycle after an accepted start
// until done; done is a one-cycle pulse with resultSub/errorSub/overflowSub valid in that cycle and held afterwards.
interface fp32_subtractor_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  round_mode;
  logic        busy;
  logic        done;
  logic        errorSub;
  logic        overflowSub;
  logic [31:0] resultSub;

  modport master (
    output start, A, B, round_mode,
    input  busy, done, errorSub, overflowSub, resultSub
  );

  modport slave (
    input  start, A, B, round_mode,
    output busy, done, errorSub, overflowSub, resultSub
  );
endinterface

// File: rtl/fp32_subtractor_seq.sv
// Multi-cycle FP32 subtractor (A - B) with guard/round/sticky rounding and special-operand handling.
// Define FPSUB_FAST_ALIGN_EN for single-cycle ALIGN/NORM (barrel shift + leading-zero count); default is bit-serial.
module fp32_subtractor_seq #(
    parameter int ALIGN_CAP = 26
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fp32_subtractor_seq_if.slave        bus,
    output logic [2:0]                  state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_PACK
    } state_t;

    state_t state, state_next;

    logic [31:0] a_q, b_q;
    logic [1:0]  rm_q;
    logic        sign_big, sign_small, res_sign;
    logic [9:0]  exp_w;
    logic [7:0]  diff;
    logic [26:0] m_big, m_small;
    logic [27:0] sum;
    logic [31:0] res_pend;
    logic        err_pend, ovf_pend;

    // Unpack: B's sign is inverted so the rest of the datapath is a plain signed add.
    logic        sa, sb_eff, a_big, is_special, is_invalid;
    logic [7:0]  ea, eb;
    logic [26:0] ma, mb;
    logic [31:0] special_res;
    always_comb begin
        sa          = a_q[31];
        sb_eff      = ~b_q[31];
        ea          = a_q[30:23];
        eb          = b_q[30:23];
        ma          = (ea == 8'd0) ? 27'd0 : {1'b1, a_q[22:0], 3'b000};
        mb          = (eb == 8'd0) ? 27'd0 : {1'b1, b_q[22:0], 3'b000};
        a_big       = (ea >= eb);
        is_special  = (ea == 8'hFF) || (eb == 8'hFF);
        is_invalid  = ((ea == 8'hFF) && (a_q[22:0] != 23'd0)) ||
                      ((eb == 8'hFF) && (b_q[22:0] != 23'd0)) ||
                      ((ea == 8'hFF) && (eb == 8'hFF) && (a_q[31] == b_q[31]));
        if (is_invalid)        special_res = 32'h7FC00000;
        else if (ea == 8'hFF)  special_res = {sa, 8'hFF, 23'd0};
        else                   special_res = {sb_eff, 8'hFF, 23'd0};
    end

    logic [26:0] small_aligned;
    logic [7:0]  diff_next;
    logic        align_last;
`ifdef FPSUB_FAST_ALIGN_EN
    logic [26:0] lost_mask;
    always_comb begin
        lost_mask     = (27'd1 << diff) - 27'd1;
        small_aligned = (m_small >> diff) | {26'd0, |(m_small & lost_mask)};
        if (diff >= 8'(ALIGN_CAP)) small_aligned = {26'd0, |m_small};
        diff_next     = 8'd0;
        align_last    = 1'b1;
    end
`else
    always_comb begin
        small_aligned = m_small;
        diff_next     = diff;
        align_last    = 1'b1;
        if (diff >= 8'(ALIGN_CAP)) begin
            small_aligned = {26'd0, |m_small};
            diff_next     = 8'd0;
        end else if (diff != 8'd0) begin
            small_aligned = {1'b0, m_small[26:2], m_small[1] | m_small[0]};
            diff_next     = diff - 8'd1;
            align_last    = (diff == 8'd1);
        end
    end
`endif

    logic [27:0] sum_c;
    logic        sign_c;
    always_comb begin
        sum_c  = 28'd0;
        sign_c = sign_big;
        if (sign_big == sign_small)  sum_c = {1'b0, m_big} + {1'b0, m_small};
        else if (m_big >= m_small)   sum_c = {1'b0, m_big - m_small};
        else begin
            sum_c  = {1'b0, m_small - m_big};
            sign_c = sign_small;
        end
    end

    // Normalize: carry shifts right once; otherwise shift left until bit 26 is set or the exponent bottoms out.
    logic [27:0] norm_sum;
    logic [9:0]  norm_exp;
    logic        norm_flush, norm_last;
`ifdef FPSUB_FAST_ALIGN_EN
    logic [4:0]  lz;
    logic        lz_found;
`endif
    always_comb begin
        norm_sum   = sum;
        norm_exp   = exp_w;
        norm_flush = 1'b0;
        norm_last  = 1'b1;
`ifdef FPSUB_FAST_ALIGN_EN
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_found) begin
                if (sum[i]) lz_found = 1'b1;
                else        lz = lz + 5'd1;
            end
        end
`endif
        if (sum[27]) begin
            norm_sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            norm_exp = exp_w + 10'd1;
        end else if (!sum[26]) begin
`ifdef FPSUB_FAST_ALIGN_EN
            if (exp_w <= {5'd0, lz}) norm_flush = 1'b1;
            else begin
                norm_sum = sum << lz;
                norm_exp = exp_w - {5'd0, lz};
            end
`else
            if (exp_w == 10'd1) norm_flush = 1'b1;
            else begin
                norm_sum  = {sum[26:0], 1'b0};
                norm_exp  = exp_w - 10'd1;
                norm_last = sum[25];
            end
`endif
        end
    end

    logic        inc, to_inf, round_ovf;
    logic [24:0] rsum;
    logic [9:0]  rexp;
    logic [22:0] rfrac;
    logic [31:0] round_res;
    always_comb begin
        case (rm_q)
            2'b00:   inc = 1'b0;
            2'b01:   inc = sum[2] & (sum[1] | sum[0] | sum[3]);
            2'b10:   inc = (|sum[2:0]) & ~res_sign;
            default: inc = (|sum[2:0]) & res_sign;
        endcase
        rsum = {1'b0, sum[26:3]} + {24'd0, inc};
        if (rsum[24]) begin
            rexp  = exp_w + 10'd1;
            rfrac = rsum[23:1];
        end else begin
            rexp  = exp_w;
            rfrac = rsum[22:0];
        end
        round_ovf = (rexp >= 10'd255);
        to_inf    = (rm_q == 2'b01) || ((rm_q == 2'b10) && !res_sign) || ((rm_q == 2'b11) && res_sign);
        if (round_ovf) round_res = to_inf ? {res_sign, 8'hFF, 23'd0} : {res_sign, 8'hFE, 23'h7FFFFF};
        else           round_res = {res_sign, rexp[7:0], rfrac};
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.start) state_next = S_UNPACK;
            S_UNPACK: state_next = is_special ? S_PACK : S_ALIGN;
            S_ALIGN:  if (align_last) state_next = S_ADDSUB;
            S_ADDSUB: state_next = (sum_c == 28'd0) ? S_PACK : S_NORM;
            S_NORM: begin
                if (norm_flush)     state_next = S_PACK;
                else if (norm_last) state_next = S_ROUND;
            end
            S_ROUND:  state_next = S_PACK;
            S_PACK:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= 32'd0;  b_q <= 32'd0;  rm_q <= 2'd0;
            sign_big <= 1'b0;  sign_small <= 1'b0;  res_sign <= 1'b0;
            exp_w <= 10'd0;  diff <= 8'd0;
            m_big <= 27'd0;  m_small <= 27'd0;  sum <= 28'd0;
            res_pend <= 32'd0;  err_pend <= 1'b0;  ovf_pend <= 1'b0;
            bus.busy <= 1'b0;  bus.done <= 1'b0;
            bus.errorSub <= 1'b0;  bus.overflowSub <= 1'b0;  bus.resultSub <= 32'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    a_q <= bus.A;  b_q <= bus.B;  rm_q <= bus.round_mode;
                    bus.busy <= 1'b1;
                    bus.errorSub <= 1'b0;  bus.overflowSub <= 1'b0;
                end
                S_UNPACK: begin
                    err_pend <= is_special & is_invalid;
                    ovf_pend <= 1'b0;
                    res_pend <= special_res;
                    if (a_big) begin
                        m_big <= ma;  m_small <= mb;  sign_big <= sa;  sign_small <= sb_eff;
                        exp_w <= {2'b00, ea};  diff <= ea - eb;
                    end else begin
                        m_big <= mb;  m_small <= ma;  sign_big <= sb_eff;  sign_small <= sa;
                        exp_w <= {2'b00, eb};  diff <= eb - ea;
                    end
                end
                S_ALIGN: begin
                    m_small <= small_aligned;
                    diff    <= diff_next;
                end
                S_ADDSUB: begin
                    sum      <= sum_c;
                    res_sign <= sign_c;
                    if (sum_c == 28'd0) res_pend <= {(rm_q == 2'b11), 31'd0};
                end
                S_NORM: begin
                    if (norm_flush) res_pend <= {res_sign, 31'd0};
                    else begin
                        sum   <= norm_sum;
                        exp_w <= norm_exp;
                    end
                end
                S_ROUND: begin
                    res_pend <= round_res;
                    ovf_pend <= round_ovf;
                end
                S_PACK: begin
                    bus.resultSub   <= res_pend;
                    bus.errorSub    <= err_pend;
                    bus.overflowSub <= ovf_pend;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_subtractor_seq.sv
// Directed-vector bench for fp32_subtractor_seq; also builds with FPSUB_FAST_ALIGN_EN defined.
module tb_fp32_subtractor_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;
    int         total = 0;
    int         bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fp32_subtractor_seq_if bus();
    fp32_subtractor_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg));

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] res;
        logic        err;
        logic        ovf;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Issue one operation and follow it to done, recording latency and handshake behaviour.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         output logic [31:0] res, output logic err, output logic ovf,
                         output int lat, output logic seen, output logic busy_gap,
                         output logic busy_at_done, output logic done_after);
        @(negedge clk);
        bus.A = a;  bus.B = b;  bus.round_mode = rm;  bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        busy_gap = !bus.busy;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (!bus.done && !bus.busy) busy_gap = 1'b1;
        end
        seen = bus.done;
        res = bus.resultSub;  err = bus.errorSub;  ovf = bus.overflowSub;
        busy_at_done = bus.busy;
        @(posedge clk); #1;
        done_after = bus.done;
    endtask

    logic [31:0] res, got;
    logic        err, ovf, seen, busy_gap, busy_at_done, done_after;
    int          lat, ndone, w;

    initial begin
        #20_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h40400000, 32'h3F800000, 2'b01, 32'h40000000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 2'b00, 32'h00000000, 1'b0, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 2'b11, 32'h80000000, 1'b0, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h33000000, 2'b01, 32'h3F800000, 1'b0, 1'b0};
        vecs[4]  = '{32'h3F800000, 32'h33000000, 2'b00, 32'h3F7FFFFF, 1'b0, 1'b0};
        vecs[5]  = '{32'h3F800000, 32'h33800000, 2'b01, 32'h3F7FFFFF, 1'b0, 1'b0};
        vecs[6]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 2'b01, 32'h7F800000, 1'b0, 1'b1};
        vecs[7]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 2'b00, 32'h7F7FFFFF, 1'b0, 1'b1};
        vecs[8]  = '{32'h7F800000, 32'h7F800000, 2'b01, 32'h7FC00000, 1'b1, 1'b0};
        vecs[9]  = '{32'h3F800000, 32'h40400000, 2'b01, 32'hC0000000, 1'b0, 1'b0};
        vecs[10] = '{32'h3FC00000, 32'hC0200000, 2'b01, 32'h40800000, 1'b0, 1'b0};
        vecs[11] = '{32'h7FC00001, 32'h3F800000, 2'b01, 32'h7FC00000, 1'b1, 1'b0};
        vecs[12] = '{32'h7F800000, 32'h3F800000, 2'b01, 32'h7F800000, 1'b0, 1'b0};
        vecs[13] = '{32'h3F800000, 32'h7F800000, 2'b01, 32'hFF800000, 1'b0, 1'b0};
        vecs[14] = '{32'hFF800000, 32'h7F800000, 2'b01, 32'hFF800000, 1'b0, 1'b0};
        vecs[15] = '{32'h4F000000, 32'h3F800000, 2'b00, 32'h4EFFFFFF, 1'b0, 1'b0};
        vecs[16] = '{32'h4F000000, 32'h3F800000, 2'b01, 32'h4F000000, 1'b0, 1'b0};
        vecs[17] = '{32'hCF000000, 32'hBF800000, 2'b10, 32'hCEFFFFFF, 1'b0, 1'b0};
        vecs[18] = '{32'hCF000000, 32'hBF800000, 2'b11, 32'hCF000000, 1'b0, 1'b0};
        vecs[19] = '{32'h00800000, 32'h00C00000, 2'b01, 32'h80000000, 1'b0, 1'b0};
        vecs[20] = '{32'h40000000, 32'h00000000, 2'b01, 32'h40000000, 1'b0, 1'b0};
        vecs[21] = '{32'h00000000, 32'h40000000, 2'b01, 32'hC0000000, 1'b0, 1'b0};
        vecs[22] = '{32'h00000001, 32'h00000000, 2'b01, 32'h00000000, 1'b0, 1'b0};
        vecs[23] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 2'b10, 32'h7F800000, 1'b0, 1'b1};
        vecs[24] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 2'b11, 32'h7F7FFFFF, 1'b0, 1'b1};
        vecs[25] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 2'b11, 32'hFF800000, 1'b0, 1'b1};

        bus.start = 1'b0;  bus.A = 32'd0;  bus.B = 32'd0;  bus.round_mode = 2'b00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err",  {31'd0, bus.errorSub}, 32'd0);
        chk("rst_ovf",  {31'd0, bus.overflowSub}, 32'd0);
        chk("rst_res",  bus.resultSub, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            exp_q.push_back(vecs[i].res);
            do_op(vecs[i].a, vecs[i].b, vecs[i].rm, res, err, ovf, lat, seen, busy_gap, busy_at_done, done_after);
            chk($sformatf("v%0d_done_seen", i), {31'd0, seen}, 32'd1);
            chk($sformatf("v%0d_res", i), res, exp_q.pop_front());
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
            chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
            chk($sformatf("v%0d_done_width", i), {31'd0, done_after}, 32'd0);
            chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy_at_done}, 32'd0);
            if (i == 0) begin
                chk("v0_latency", lat, 32'd7);
                chk("v0_busy_gap", {31'd0, busy_gap}, 32'd0);
            end
            if (i == 8) chk("v8_latency_special", lat, 32'd3);
            if (i == 3) begin
`ifdef FPSUB_FAST_ALIGN_EN
                chk("v3_latency", lat, 32'd7);
`else
                chk("v3_latency", lat, 32'd31);
`endif
            end
        end

        // A second start while busy must be ignored
        @(negedge clk);
        bus.A = 32'h40400000;  bus.B = 32'h3F800000;  bus.round_mode = 2'b01;  bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.A = 32'h3F800000;  bus.B = 32'h40400000;  bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        got = 32'hDEADBEEF;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                got = bus.resultSub;
            end
        end
        chk("busy_ignore_done_count", ndone, 32'd1);
        chk("busy_ignore_res", got, 32'h40000000);

        // Reset asserted mid-ALIGN aborts the operation
        @(negedge clk);
        bus.A = 32'h3F800000;  bus.B = 32'h33000000;  bus.round_mode = 2'b01;  bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        w = 0;
        while (state_dbg != 3'd2 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("abort_reach_align", {29'd0, state_dbg}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_res",  bus.resultSub, 32'd0);
        chk("abort_err",  {31'd0, bus.errorSub}, 32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);

        do_op(32'h40400000, 32'h3F800000, 2'b01, res, err, ovf, lat, seen, busy_gap, busy_at_done, done_after);
        chk("post_abort_seen", {31'd0, seen}, 32'd1);
        chk("post_abort_res", res, 32'h40000000);
        chk("post_abort_latency", lat, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
